bomb_seq_ctrl: RTL and testbench

BOMB_SEQ_CTRL -- requirements
Module: bomb_seq_ctrl

---
 rtl/bomb_pkg.sv | 37 +++
 rtl/bomb_seq_ctrl_if.sv | 14 +
 rtl/bcd_down2.sv | 43 ++++
 rtl/bomb_seq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_bomb_seq_ctrl.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bomb_pkg.sv
// bomb_pkg
// Shared definitions for the bomb sequence controller: state encoding,
// PS/2 prefix bytes, the display blank code, the default defuse codes,
// countdown start value and mismatch limit, plus the LED thermometer helper.
// No ports; imported by bcd_down2 and bomb_seq_ctrl.
package bomb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_ARMED    = 2'b01,
        ST_DEFUSED  = 2'b10,
        ST_EXPLODED = 2'b11
    } bomb_state_t;

    localparam logic [7:0] BREAK_PREFIX = 8'hF0;
    localparam logic [7:0] EXT_PREFIX   = 8'hE0;
    localparam logic [3:0] BLANK_CODE   = 4'hB;

    localparam logic [7:0] DEF_CODE0     = 8'h2C;
    localparam logic [7:0] DEF_CODE1     = 8'h35;
    localparam logic [7:0] DEF_CODE2     = 8'h3A;
    localparam logic [7:0] DEF_CODE3     = 8'h4B;
    localparam logic [7:0] DEF_START_BCD = 8'h30;
    localparam logic [3:0] DEF_MAX_ERR   = 4'hA;

    // Number of matched codes -> LED bar with that many lit segments.
    function automatic logic [3:0] thermo(input logic [2:0] n);
        case (n)
            3'd0:    thermo = 4'b0000;
            3'd1:    thermo = 4'b0001;
            3'd2:    thermo = 4'b0011;
            3'd3:    thermo = 4'b0111;
            default: thermo = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/bomb_seq_ctrl_if.sv
// bomb_seq_ctrl_if
// Handshake between the PS/2 receive FIFO and the sequence controller.
//   rx_valid : FIFO holds a byte
//   rx_data  : scan-code byte at the FIFO head
//   rx_ready : pop strobe; a byte is consumed when rx_valid & rx_ready
// master = FIFO side, slave = controller side.
interface bomb_seq_ctrl_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;

    modport master (output rx_valid, output rx_data, input rx_ready);
    modport slave  (input rx_valid, input rx_data, output rx_ready);
endinterface

// File: rtl/bcd_down2.sv
// bcd_down2
// Two-digit BCD down-counter for the countdown display.
//   clk      : system clock
//   load     : synchronous load of load_val (highest priority)
//   load_val : two BCD digits loaded on load
//   blank    : overwrite both digits with the blank/alarm code
//   en       : decrement by one (held at 00)
//   hi, lo   : registered BCD digits
//   zero     : count is 00
module bcd_down2
    import bomb_pkg::*;
(
    input  logic       clk,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       blank,
    input  logic       en,
    output logic [3:0] hi,
    output logic [3:0] lo,
    output logic       zero
);

    assign zero = (hi == 4'd0) && (lo == 4'd0);

    // Borrow from the tens digit when the units digit wraps 0 -> 9.
    always_ff @(posedge clk) begin
        if (load) begin
            hi <= load_val[7:4];
            lo <= load_val[3:0];
        end else if (blank) begin
            hi <= BLANK_CODE;
            lo <= BLANK_CODE;
        end else if (en && !zero) begin
            if (lo == 4'd0) begin
                lo <= 4'd9;
                hi <= hi - 4'd1;
            end else begin
                lo <= lo - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bomb_seq_ctrl.sv
// bomb_seq_ctrl
// Defuse-code sequencer for the bomb game. While ARMED it pops PS/2 scan
// codes, matches make codes against CODE0..CODE3 in order, counts
// mismatches, and runs a BCD countdown; it ends DEFUSED or EXPLODED.
//   clk        : system clock
//   clr        : synchronous active-high reset
//   arm        : pulse, IDLE -> ARMED
//   tick       : 1 Hz enable, decrements the countdown while ARMED
//   rx         : FIFO handshake (bomb_seq_ctrl_if.slave)
//   state      : 00 IDLE, 01 ARMED, 10 DEFUSED, 11 EXPLODED
//   led        : thermometer of matched codes
//   digit_hi/lo: BCD countdown, BB once exploded
//   err_count  : accepted mismatches, saturating at F
// Optional feature: define BOMB_SEQ_CTRL_TYPEMATIC_FILTER_EN to ignore
// typematic repeats of the last matched code until its break is seen.
module bomb_seq_ctrl
    import bomb_pkg::*;
#(
    parameter logic [7:0] CODE0     = DEF_CODE0,
    parameter logic [7:0] CODE1     = DEF_CODE1,
    parameter logic [7:0] CODE2     = DEF_CODE2,
    parameter logic [7:0] CODE3     = DEF_CODE3,
    parameter logic [7:0] START_BCD = DEF_START_BCD,
    parameter logic [3:0] MAX_ERR   = DEF_MAX_ERR
)
(
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  arm,
    input  logic                  tick,
    bomb_seq_ctrl_if.slave        rx,
    output logic [1:0]            state,
    output logic [3:0]            led,
    output logic [3:0]            digit_hi,
    output logic [3:0]            digit_lo,
    output logic [3:0]            err_count
);

    bomb_state_t state_q;
    logic [2:0]  idx;
    logic        brk;
    logic        ready_q;

    logic        armed;
    logic        byte_in;
    logic        brk_pop;
    logic        f0_pop;
    logic        make;
    logic        repeat_hit;
    logic        match;
    logic        miss;
    logic        defuse;
    logic        cnt_en;
    logic        last_tick;
    logic        boom;
    logic        cnt_zero;
    logic [7:0]  want;
    logic [3:0]  err_next;

    assign state = state_q;

    // The ready flop drops on the clr edge; gating with clr as well keeps
    // the FIFO from losing a byte on the first cycle clr is raised.
    assign rx.rx_ready = ready_q & ~clr;

`ifdef BOMB_SEQ_CTRL_TYPEMATIC_FILTER_EN
    // held stays set from a match until that key's break code is popped.
    logic       held;
    logic [7:0] last_code;
    assign repeat_hit = held && (rx.rx_data == last_code);
`else
    assign repeat_hit = 1'b0;
`endif

    // Byte classification and terminal conditions for this edge.
    always_comb begin
        armed    = (state_q == ST_ARMED);
        byte_in  = rx.rx_valid & ready_q & ~clr & armed;
        brk_pop  = byte_in & brk;
        f0_pop   = byte_in & ~brk & (rx.rx_data == BREAK_PREFIX);
        make     = byte_in & ~brk & (rx.rx_data != BREAK_PREFIX)
                   & (rx.rx_data != EXT_PREFIX) & ~repeat_hit;
        case (idx)
            3'd0:    want = CODE0;
            3'd1:    want = CODE1;
            3'd2:    want = CODE2;
            default: want = CODE3;
        endcase
        match    = make & (rx.rx_data == want);
        miss     = make & (rx.rx_data != want);
        err_next = err_count;
        if (miss && err_count != 4'hF) begin
            err_next = err_count + 4'd1;
        end
        defuse    = match & (idx == 3'd3);
        cnt_en    = armed & tick;
        last_tick = cnt_en & ({digit_hi, digit_lo} == 8'h01);
        // A completed code beats a simultaneous terminal tick.
        boom      = armed & ~defuse
                    & (last_tick | (miss & (err_next == MAX_ERR)) | cnt_zero);
    end

    // Sequencing FSM; DEFUSED and EXPLODED hold until clr.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            idx       <= 3'd0;
            brk       <= 1'b0;
            led       <= 4'b0000;
            err_count <= 4'd0;
            ready_q   <= 1'b0;
`ifdef BOMB_SEQ_CTRL_TYPEMATIC_FILTER_EN
            held      <= 1'b0;
            last_code <= 8'h00;
`endif
        end else begin
            ready_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        state_q <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (brk_pop) begin
                        brk <= 1'b0;
`ifdef BOMB_SEQ_CTRL_TYPEMATIC_FILTER_EN
                        if (rx.rx_data == last_code) begin
                            held <= 1'b0;
                        end
`endif
                    end
                    if (f0_pop) begin
                        brk <= 1'b1;
                    end
                    if (match) begin
                        idx <= idx + 3'd1;
                        led <= thermo(idx + 3'd1);
`ifdef BOMB_SEQ_CTRL_TYPEMATIC_FILTER_EN
                        held      <= 1'b1;
                        last_code <= rx.rx_data;
`endif
                    end
                    if (miss) begin
                        idx       <= 3'd0;
                        led       <= 4'b0000;
                        err_count <= err_next;
                    end
                    if (defuse) begin
                        state_q <= ST_DEFUSED;
                    end else if (boom) begin
                        state_q <= ST_EXPLODED;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    bcd_down2 u_count (
        .clk      (clk),
        .load     (clr),
        .load_val (START_BCD),
        .blank    (boom),
        .en       (cnt_en),
        .hi       (digit_hi),
        .lo       (digit_lo),
        .zero     (cnt_zero)
    );

endmodule

// File: tb/tb_bomb_seq_ctrl.sv
// tb_bomb_seq_ctrl
// Self-checking bench for bomb_seq_ctrl: directed scenarios with fixed
// expectations plus a randomized run against a behavioural model.
// Honours BOMB_SEQ_CTRL_TYPEMATIC_FILTER_EN when defined.
module tb_bomb_seq_ctrl;

    logic       clk = 1'b0;
    logic       clr, arm, tick;
    logic [1:0] state;
    logic [3:0] led, digit_hi, digit_lo, err_count;

    bomb_seq_ctrl_if rx_if ();

    bomb_seq_ctrl dut (
        .clk       (clk),
        .clr       (clr),
        .arm       (arm),
        .tick      (tick),
        .rx        (rx_if),
        .state     (state),
        .led       (led),
        .digit_hi  (digit_hi),
        .digit_lo  (digit_lo),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

`ifdef BOMB_SEQ_CTRL_TYPEMATIC_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif
    localparam int MAX_ERR = 10;
    localparam int START   = 30;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: count kept as a plain decimal number.
    int         m_state, m_idx, m_err, m_count;
    bit         m_brk, m_held, m_ready, m_clr_now;
    logic [7:0] m_last;
    logic [7:0] codes [4] = '{8'h2C, 8'h35, 8'h3A, 8'h4B};

    task automatic model_edge(input bit c, input bit a, input bit t, input bit v, input logic [7:0] d);
        bit pop, defused, boom;
        pop     = v && !c && m_ready;
        defused = 1'b0;
        boom    = 1'b0;
        if (c) begin
            m_state = 0; m_idx = 0; m_err = 0; m_count = START;
            m_brk = 0; m_held = 0; m_last = 8'h00; m_ready = 0;
        end else begin
            m_ready = 1;
            if (m_state == 0) begin
                if (a) m_state = 1;
            end else if (m_state == 1) begin
                if (pop) begin
                    if (m_brk) begin
                        m_brk = 0;
                        if (m_held && d == m_last) m_held = 0;
                    end else if (d == 8'hF0) begin
                        m_brk = 1;
                    end else if (d == 8'hE0) begin
                        m_brk = m_brk;
                    end else if (FILTER && m_held && d == m_last) begin
                        m_brk = m_brk;
                    end else if (d == codes[m_idx]) begin
                        m_idx++;
                        m_held = 1;
                        m_last = d;
                        if (m_idx == 4) defused = 1;
                    end else begin
                        if (m_err < 15) m_err++;
                        m_idx = 0;
                        if (m_err == MAX_ERR) boom = 1;
                    end
                end
                if (t) begin
                    if (m_count == 1) boom = 1;
                    if (m_count > 0) m_count--;
                end
                if (defused) m_state = 2;
                else if (boom) m_state = 3;
            end
        end
    endtask

    task automatic step(input bit c, input bit a, input bit t, input bit v, input logic [7:0] d);
        clr = c; arm = a; tick = t;
        rx_if.rx_valid = v; rx_if.rx_data = d;
        @(posedge clk);
        model_edge(c, a, t, v, d);
        m_clr_now = c;
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b0, 1'b0, 1'b0, 1'b1, d);
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 1, 8'h2C);
        checks++; if (state !== 2'b00) begin failures++; $display("[TB] FAIL reset_state got=%b want=00", state); end
        checks++; if (led !== 4'b0000) begin failures++; $display("[TB] FAIL reset_led got=%b want=0000", led); end
        checks++; if (err_count !== 4'h0) begin failures++; $display("[TB] FAIL reset_err got=%h want=0", err_count); end
        checks++; if ({digit_hi, digit_lo} !== 8'h30) begin failures++; $display("[TB] FAIL reset_digits got=%h want=30", {digit_hi, digit_lo}); end
        checks++; if (rx_if.rx_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got=%b want=0", rx_if.rx_ready); end
        step(0, 0, 0, 0, 8'h00);
        checks++; if (rx_if.rx_ready !== 1'b1) begin failures++; $display("[TB] FAIL idle_ready got=%b want=1", rx_if.rx_ready); end
        send(8'h2C);
        send(8'h1C);
        checks++; if (state !== 2'b00 || err_count !== 4'h0 || led !== 4'b0000) begin
            failures++; $display("[TB] FAIL idle_discard got state=%b err=%h led=%b want 00/0/0000", state, err_count, led);
        end
    endtask

    task automatic test_defuse();
        logic [7:0] seq [10] = '{8'h2C, 8'hF0, 8'h2C, 8'h35, 8'hF0, 8'h35, 8'h3A, 8'hF0, 8'h3A, 8'h4B};
        logic [3:0] leds [10] = '{4'h1, 4'h1, 4'h1, 4'h3, 4'h3, 4'h3, 4'h7, 4'h7, 4'h7, 4'hF};
        step(1, 0, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        checks++; if (state !== 2'b01) begin failures++; $display("[TB] FAIL arm_state got=%b want=01", state); end
        for (int i = 0; i < 10; i++) begin
            send(seq[i]);
            checks++; if (led !== leds[i]) begin failures++; $display("[TB] FAIL defuse_led[%0d] got=%b want=%b", i, led, leds[i]); end
        end
        checks++; if (state !== 2'b10) begin failures++; $display("[TB] FAIL defuse_state got=%b want=10", state); end
        checks++; if (err_count !== 4'h0) begin failures++; $display("[TB] FAIL defuse_err got=%h want=0", err_count); end
        step(0, 1, 1, 1, 8'h1C);
        step(0, 0, 1, 0, 8'h00);
        checks++; if (state !== 2'b10 || {digit_hi, digit_lo} !== 8'h30 || err_count !== 4'h0) begin
            failures++; $display("[TB] FAIL defuse_frozen got state=%b digits=%h err=%h want 10/30/0", state, {digit_hi, digit_lo}, err_count);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] want;
        step(1, 0, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        for (int k = 1; k <= 30; k++) begin
            step(0, 0, 1, 0, 8'h00);
            if (k < 30) begin
                want = {4'((START - k) / 10), 4'((START - k) % 10)};
                checks++; if ({digit_hi, digit_lo} !== want || state !== 2'b01) begin
                    failures++; $display("[TB] FAIL countdown[%0d] got digits=%h state=%b want %h/01", k, {digit_hi, digit_lo}, state, want);
                end
            end else begin
                checks++; if ({digit_hi, digit_lo} !== 8'hBB || state !== 2'b11) begin
                    failures++; $display("[TB] FAIL timeout got digits=%h state=%b want BB/11", {digit_hi, digit_lo}, state);
                end
            end
        end
    endtask

    task automatic test_errors();
        step(1, 0, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        for (int k = 1; k <= 10; k++) begin
            send(8'h1C);
            checks++; if (err_count !== 4'(k) || led !== 4'b0000 || state !== ((k < 10) ? 2'b01 : 2'b11)) begin
                failures++; $display("[TB] FAIL errors[%0d] got err=%h led=%b state=%b", k, err_count, led, state);
            end
        end
        send(8'h2C);
        step(0, 0, 1, 0, 8'h00);
        checks++; if (state !== 2'b11 || {digit_hi, digit_lo} !== 8'hBB || err_count !== 4'hA) begin
            failures++; $display("[TB] FAIL exploded_hold got state=%b digits=%h err=%h want 11/BB/A", state, {digit_hi, digit_lo}, err_count);
        end
    endtask

    task automatic test_restart();
        step(1, 0, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        send(8'h2C);
        send(8'hE0);
        send(8'h35);
        checks++; if (led !== 4'b0011) begin failures++; $display("[TB] FAIL restart_pre got=%b want=0011", led); end
        send(8'h1C);
        checks++; if (led !== 4'b0000 || err_count !== 4'h1) begin failures++; $display("[TB] FAIL restart_miss got led=%b err=%h want 0000/1", led, err_count); end
        send(8'h2C);
        checks++; if (led !== 4'b0001) begin failures++; $display("[TB] FAIL restart_again got=%b want=0001", led); end
    endtask

    task automatic test_typematic();
        step(1, 0, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        send(8'h2C);
        send(8'h2C);
        if (FILTER) begin
            send(8'hF0);
            send(8'h2C);
            send(8'h35);
            checks++; if (led !== 4'b0011 || err_count !== 4'h0) begin
                failures++; $display("[TB] FAIL typematic_on got led=%b err=%h want 0011/0", led, err_count);
            end
        end else begin
            checks++; if (led !== 4'b0000 || err_count !== 4'h1) begin
                failures++; $display("[TB] FAIL typematic_off got led=%b err=%h want 0000/1", led, err_count);
            end
        end
    endtask

    task automatic test_same_edge_and_clr();
        step(1, 0, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        for (int k = 0; k < 29; k++) step(0, 0, 1, 0, 8'h00);
        checks++; if ({digit_hi, digit_lo} !== 8'h01) begin failures++; $display("[TB] FAIL at_one got=%h want=01", {digit_hi, digit_lo}); end
        send(8'h2C);
        send(8'h35);
        send(8'h3A);
        step(0, 0, 1, 1, 8'h4B);
        checks++; if (state !== 2'b10 || {digit_hi, digit_lo} !== 8'h00 || led !== 4'hF) begin
            failures++; $display("[TB] FAIL same_edge got state=%b digits=%h led=%b want 10/00/1111", state, {digit_hi, digit_lo}, led);
        end
        step(1, 0, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        send(8'h2C);
        send(8'h35);
        send(8'hF0);
        step(1, 0, 0, 1, 8'h3A);
        checks++; if (state !== 2'b00 || {digit_hi, digit_lo} !== 8'h30 || led !== 4'b0000 || rx_if.rx_ready !== 1'b0) begin
            failures++; $display("[TB] FAIL mid_clr got state=%b digits=%h led=%b ready=%b want 00/30/0000/0", state, {digit_hi, digit_lo}, led, rx_if.rx_ready);
        end
        step(0, 1, 0, 0, 8'h00);
        send(8'h2C);
        checks++; if (led !== 4'b0001 || err_count !== 4'h0) begin
            failures++; $display("[TB] FAIL after_clr got led=%b err=%h want 0001/0", led, err_count);
        end
    endtask

    task automatic test_random();
        for (int ep = 0; ep < 8; ep++) begin
            step(1, 0, 0, 0, 8'h00);
            for (int n = 0; n < 250; n++) begin
                bit         c, a, t, v;
                logic [7:0] d;
                int         r;
                logic [3:0] el, ehi, elo;
                c = ($urandom_range(0, 199) == 0);
                a = ($urandom_range(0, 9) == 0);
                t = ($urandom_range(0, 7) == 0);
                v = ($urandom_range(0, 2) != 0);
                r = $urandom_range(0, 9);
                if (r < 4) d = codes[$urandom_range(0, 3)];
                else if (r == 4) d = codes[(m_idx < 4) ? m_idx : 0];
                else if (r == 5) d = 8'hF0;
                else if (r == 6) d = 8'hE0;
                else d = 8'($urandom);
                step(c, a, t, v, d);
                el  = 4'((1 << m_idx) - 1);
                ehi = (m_state == 3) ? 4'hB : 4'(m_count / 10);
                elo = (m_state == 3) ? 4'hB : 4'(m_count % 10);
                checks++;
                if (state !== 2'(m_state) || led !== el || err_count !== 4'(m_err)
                    || digit_hi !== ehi || digit_lo !== elo || rx_if.rx_ready !== (!m_clr_now && m_ready)) begin
                    failures++;
                    $display("[TB] FAIL random[%0d.%0d] got st=%b led=%b err=%h dig=%h%h rdy=%b want st=%0d led=%b err=%0d dig=%h%h rdy=%b",
                             ep, n, state, led, err_count, digit_hi, digit_lo, rx_if.rx_ready,
                             m_state, el, m_err, ehi, elo, (!m_clr_now && m_ready));
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        clr = 1'b1; arm = 1'b0; tick = 1'b0;
        rx_if.rx_valid = 1'b0; rx_if.rx_data = 8'h00;
        m_ready = 0; m_clr_now = 1;
        m_state = 0; m_idx = 0; m_err = 0; m_count = START;
        m_brk = 0; m_held = 0; m_last = 8'h00;
        @(negedge clk);
        test_reset();
        test_defuse();
        test_timeout();
        test_errors();
        test_restart();
        test_typematic();
        test_same_edge_and_clr();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
